xbar_cmd_arbiter: RTL

// - Initiator/command side of the 16-in/8-out one-hot crossbar: builds its i_valid/i_data_bus/i_cmd/i_en each cycle.
// - Sources present a binary destination ID; one round-robin arbiter per output grants at most one source.
// - Grants are returned to sources as a valid/ready handshake; winners' data and the one-hot command leave on one aligned register stage.

---
 rtl/xbar_cmd_arbiter_pkg.sv | 22 ++
 rtl/xbar_cmd_arbiter_if.sv | 37 +++
 rtl/xbar_cmd_arbiter_rr_arbiter.sv | 49 ++++
 rtl/xbar_cmd_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/xbar_cmd_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : xbar_pkg                                                |
// | Desc   : Shared defaults and command-index helper for the         |
// |          crossbar command arbiter.                                |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package xbar_pkg;

    localparam int DATA_WIDTH_DEF      = 32;
    localparam int NUM_OUTPUT_DATA_DEF = 8;
    localparam int NUM_INPUT_DATA_DEF  = 16;
    localparam int DEST_WIDTH_DEF      = $clog2(NUM_OUTPUT_DATA_DEF);
    localparam int SRC_WIDTH_DEF       = $clog2(NUM_INPUT_DATA_DEF);

    // Bit position of "source s routes to output d" in the flat command vector.
    function automatic int cmd_idx(input int s, input int d, input int n_out);
        return s * n_out + d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_cmd_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : xbar_cmd_arbiter_if                                     |
// | Desc   : Source request handshake plus registered crossbar-side   |
// |          command bus.                                             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface xbar_cmd_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int NUM_INPUT_DATA  = 16
);
    localparam int DEST_WIDTH    = $clog2(NUM_OUTPUT_DATA);
    localparam int TOTAL_COMMAND = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

    logic [NUM_INPUT_DATA-1:0]            i_req_valid;
    logic [NUM_INPUT_DATA*DEST_WIDTH-1:0] i_req_dest;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_INPUT_DATA-1:0]            o_req_ready;
    logic                                 i_hold;
    logic [NUM_INPUT_DATA-1:0]            o_valid;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_bus;
    logic [TOTAL_COMMAND-1:0]             o_cmd;
    logic                                 o_en;

    modport slave (
        input  i_req_valid, i_req_dest, i_req_data, i_hold,
        output o_req_ready, o_valid, o_data_bus, o_cmd, o_en
    );

    modport master (
        output i_req_valid, i_req_dest, i_req_data, i_hold,
        input  o_req_ready, o_valid, o_data_bus, o_cmd, o_en
    );

endinterface
`default_nettype wire

// File: rtl/xbar_cmd_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : xbar_rr_arbiter                                         |
// | Desc   : Round-robin arbiter, one-hot grant, owns its pointer.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module xbar_rr_arbiter #(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_REQ-1:0] i_req,
    output logic      [NUM_REQ-1:0] o_gnt
);

    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [IDX_WIDTH-1:0] w_gnt_idx;
    logic                 w_any;

    // Cyclic search from r_ptr; index arithmetic wraps naturally at NUM_REQ.
    always_comb begin
        o_gnt     = '0;
        w_idx     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = r_ptr + IDX_WIDTH'(i);
            if (!w_any && i_req[w_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        if (w_any) begin
            o_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_gnt_idx + IDX_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbar_cmd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : xbar_cmd_arbiter                                        |
// | Desc   : Per-output round-robin grant of source requests, driving |
// |          the crossbar valid/data/one-hot command through 1 stage. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module xbar_cmd_arbiter
    import xbar_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int NUM_OUTPUT_DATA = NUM_OUTPUT_DATA_DEF,
    parameter int NUM_INPUT_DATA  = NUM_INPUT_DATA_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    xbar_cmd_arbiter_if.slave bus
);

    localparam int DEST_WIDTH    = $clog2(NUM_OUTPUT_DATA);
    localparam int SRC_WIDTH     = $clog2(NUM_INPUT_DATA);
    localparam int TOTAL_COMMAND = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

    logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] w_req;
    logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] w_gnt;
    logic [NUM_INPUT_DATA-1:0]                      w_ready;
    logic [TOTAL_COMMAND-1:0]                       w_cmd;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]           w_data;

    logic [NUM_INPUT_DATA-1:0]            r_valid;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] r_data;
    logic [TOTAL_COMMAND-1:0]             r_cmd;
    logic                                 r_en;

    // Hold masks requests here so the arbiters see nothing and their pointers freeze.
    always_comb begin
        w_req = '0;
        for (int d = 0; d < NUM_OUTPUT_DATA; d++) begin
            for (int s = 0; s < NUM_INPUT_DATA; s++) begin
                w_req[d][s] = bus.i_req_valid[s]
                           && (bus.i_req_dest[s*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(d))
                           && !bus.i_hold;
            end
        end
    end

    for (genvar d = 0; d < NUM_OUTPUT_DATA; d++) begin : g_arb
        xbar_rr_arbiter #(
            .NUM_REQ   (NUM_INPUT_DATA),
            .IDX_WIDTH (SRC_WIDTH)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_req[d]),
            .o_gnt (w_gnt[d])
        );
    end

    always_comb begin
        w_ready = '0;
        w_cmd   = '0;
        w_data  = '0;
        for (int s = 0; s < NUM_INPUT_DATA; s++) begin
            for (int d = 0; d < NUM_OUTPUT_DATA; d++) begin
                w_ready[s] = w_ready[s] | w_gnt[d][s];
                w_cmd[cmd_idx(s, d, NUM_OUTPUT_DATA)] = w_gnt[d][s];
            end
            w_ready[s] = w_ready[s] & rst;
            if (w_ready[s]) begin
                w_data[s*DATA_WIDTH +: DATA_WIDTH] = bus.i_req_data[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_cmd   <= '0;
            r_en    <= 1'b0;
        end else begin
            r_valid <= w_ready;
            r_data  <= w_data;
            r_cmd   <= w_cmd;
            r_en    <= |w_ready;
        end
    end

    assign bus.o_req_ready = w_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_data_bus  = r_data;
    assign bus.o_cmd       = r_cmd;
    assign bus.o_en        = r_en;

endmodule
`default_nettype wire
